bit_sequence_analyzer: RTL and testbench

Parametrised successor to the quiz's button-driven digit checker. Captures a serial bit stream entered on two push-buttons ("one" and "zero") into a DEPTH-bit history shift register. On a start request it snapshots the window, counts the ones serially with a small FSM, and reports whether the count reaches THRESHOLD. It sits between the board button inputs and the result/display logic, with a busy/done handshake toward the controlling FSM.

---
 rtl/bit_sequence_analyzer.sv | 189 ++++++++++++++++++
 tb/tb_bit_sequence_analyzer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_sequence_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : bit_sequence_analyzer
// Brief    : Button-entered bit history with serial ones-count threshold check.
//            Optional debounce stage: define BIT_ANALYZER_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module bit_sequence_analyzer #(
  parameter int DEPTH           = 4,
  parameter int THRESHOLD       = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_one,
  input  logic                       btn_zero,
  input  logic                       waiting_for_user,
  input  logic                       start_verification,
  output logic [DEPTH-1:0]           last_digits,
  output logic [$clog2(DEPTH+1)-1:0] digit_count,
  output logic                       window_full,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] ones_count,
  output logic                       final_analysis
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Index 0 carries the "one" button, index 1 the "zero" button.
  logic [1:0] sync1_q, sync2_q, prev_q;
  logic [1:0] btn_level;
  logic [1:0] press;

`ifdef BIT_ANALYZER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    db_q, db_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      db_d[b]     = db_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != db_q[b]) begin
        if (db_cnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q        <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign btn_level = db_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign btn_level       = sync2_q;
`endif

  assign press = btn_level & ~prev_q;

  state_t          state_q, state_d;
  logic [DEPTH-1:0] last_q, last_d;
  logic [DEPTH-1:0] snapshot_q, snapshot_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic             final_q, final_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    snapshot_d = snapshot_q;
    count_d    = count_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    ones_d     = ones_q;
    final_d    = final_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Simultaneous presses cancel; entry only while idle and enabled.
    if (waiting_for_user && (state_q == S_IDLE) && (press[0] ^ press[1])) begin
      last_d = {last_q[DEPTH-2:0], press[0]};
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + CW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_verification) begin
          state_d    = S_COUNT;
          snapshot_d = last_q;
          acc_d      = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
        end
      end
      S_COUNT: begin
        acc_d = acc_q + CW'(snapshot_q[idx_q]);
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        ones_d  = acc_q;
        final_d = (acc_q >= CW'(THRESHOLD));
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      state_q    <= S_IDLE;
      last_q     <= '0;
      snapshot_q <= '0;
      count_q    <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      ones_q     <= '0;
      final_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync1_q    <= {btn_zero, btn_one};
      sync2_q    <= sync1_q;
      prev_q     <= btn_level;
      state_q    <= state_d;
      last_q     <= last_d;
      snapshot_q <= snapshot_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      ones_q     <= ones_d;
      final_q    <= final_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign last_digits    = last_q;
  assign digit_count    = count_q;
  assign window_full    = (count_q == CW'(DEPTH));
  assign busy           = busy_q;
  assign done           = done_q;
  assign ones_count     = ones_q;
  assign final_analysis = final_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_sequence_analyzer.sv
`default_nettype none
// Directed bench for bit_sequence_analyzer at DEPTH=4, THRESHOLD=2, no debounce.
module tb_bit_sequence_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_one, btn_zero, waiting_for_user, start_verification;
  logic [3:0] last_digits;
  logic [2:0] digit_count, ones_count;
  logic       window_full, busy, done, final_analysis;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_sequence_analyzer #(.DEPTH(4), .THRESHOLD(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_one            (btn_one),
    .btn_zero           (btn_zero),
    .waiting_for_user   (waiting_for_user),
    .start_verification (start_verification),
    .last_digits        (last_digits),
    .digit_count        (digit_count),
    .window_full        (window_full),
    .busy               (busy),
    .done               (done),
    .ones_count         (ones_count),
    .final_analysis     (final_analysis)
  );

  task automatic press(input logic is_one);
    @(negedge clk);
    if (is_one) btn_one = 1'b1; else btn_zero = 1'b1;
    repeat (4) @(negedge clk);
    btn_one  = 1'b0;
    btn_zero = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    btn_one = 1'b0;
    btn_zero = 1'b0;
    start_verification = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    btn_one = 1'b0;
    btn_zero = 1'b0;
    waiting_for_user = 1'b1;
    start_verification = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (last_digits !== 4'b0000) begin errors++; $display("FAIL reset_last: got %b expected 0000", last_digits); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", digit_count); end
    checks++; if (window_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", window_full); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
    checks++; if ({ones_count, final_analysis} !== 4'b0000) begin errors++; $display("FAIL reset_result: got %b expected 0000", {ones_count, final_analysis}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    do_reset();
    btn_one = 1'b1;
    @(negedge clk);
    checks++; if (last_digits !== 4'b0000) begin errors++; $display("FAIL latency_edge1: got %b expected 0000", last_digits); end
    @(negedge clk);
    checks++; if (last_digits !== 4'b0000) begin errors++; $display("FAIL latency_edge2: got %b expected 0000", last_digits); end
    @(negedge clk);
    checks++; if (last_digits !== 4'b0001) begin errors++; $display("FAIL latency_edge3: got %b expected 0001", last_digits); end
    btn_one = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL latency_single: got %0d expected 1", digit_count); end
  endtask

  task automatic test_entry;
    do_reset();
    press(1'b1); press(1'b0); press(1'b1);
    checks++; if ({digit_count, window_full} !== {3'd3, 1'b0}) begin errors++; $display("FAIL entry_three: got count=%0d full=%b expected 3/0", digit_count, window_full); end
    press(1'b1);
    checks++; if (last_digits !== 4'b1011) begin errors++; $display("FAIL entry_last: got %b expected 1011", last_digits); end
    checks++; if ({digit_count, window_full} !== {3'd4, 1'b1}) begin errors++; $display("FAIL entry_full: got count=%0d full=%b expected 4/1", digit_count, window_full); end
  endtask

  task automatic test_analysis;
    logic [7:0] busy_m, done_m;
    logic [2:0] ones_hold;
    busy_m = '0; done_m = '0; ones_hold = '1;
    @(negedge clk);
    start_verification = 1'b1;
    @(negedge clk);
    start_verification = 1'b0;
    for (int k = 0; k < 8; k++) begin
      busy_m[k] = busy;
      done_m[k] = done;
      if (k == 4) ones_hold = ones_count;
      @(negedge clk);
    end
    checks++; if (busy_m !== 8'h0F) begin errors++; $display("FAIL analysis_busy: got %b expected 00001111", busy_m); end
    checks++; if (done_m !== 8'h20) begin errors++; $display("FAIL analysis_done: got %b expected 00100000", done_m); end
    checks++; if (ones_hold !== 3'd0) begin errors++; $display("FAIL analysis_hold: got %0d expected 0", ones_hold); end
    checks++; if ({ones_count, final_analysis} !== {3'd3, 1'b1}) begin errors++; $display("FAIL analysis_result: got ones=%0d final=%b expected 3/1", ones_count, final_analysis); end
  endtask

  task automatic test_low;
    logic [7:0] done_m;
    done_m = '0;
    do_reset();
    press(1'b1); press(1'b0); press(1'b0); press(1'b1); press(1'b0);
    checks++; if ({last_digits, digit_count} !== {4'b0010, 3'd4}) begin errors++; $display("FAIL low_entry: got %b/%0d expected 0010/4", last_digits, digit_count); end
    @(negedge clk);
    start_verification = 1'b1;
    @(negedge clk);
    start_verification = 1'b0;
    for (int k = 0; k < 8; k++) begin
      done_m[k] = done;
      @(negedge clk);
    end
    checks++; if (done_m !== 8'h20) begin errors++; $display("FAIL low_done: got %b expected 00100000", done_m); end
    checks++; if ({ones_count, final_analysis} !== {3'd1, 1'b0}) begin errors++; $display("FAIL low_result: got ones=%0d final=%b expected 1/0", ones_count, final_analysis); end
  endtask

  task automatic test_drop;
    do_reset();
    press(1'b1); press(1'b1);
    @(negedge clk);
    btn_one = 1'b1;
    btn_zero = 1'b1;
    repeat (4) @(negedge clk);
    btn_one = 1'b0;
    btn_zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({last_digits, digit_count} !== {4'b0011, 3'd2}) begin errors++; $display("FAIL drop_both: got %b/%0d expected 0011/2", last_digits, digit_count); end
    waiting_for_user = 1'b0;
    press(1'b0);
    waiting_for_user = 1'b1;
    checks++; if ({last_digits, digit_count} !== {4'b0011, 3'd2}) begin errors++; $display("FAIL drop_disabled: got %b/%0d expected 0011/2", last_digits, digit_count); end
    press(1'b0);
    checks++; if ({last_digits, digit_count} !== {4'b0110, 3'd3}) begin errors++; $display("FAIL drop_resume: got %b/%0d expected 0110/3", last_digits, digit_count); end
  endtask

  task automatic test_busy_drop;
    int dones;
    dones = 0;
    @(negedge clk);
    start_verification = 1'b1;
    @(negedge clk);
    start_verification = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) dones++;
      if (k == 0) btn_one = 1'b1;
      if (k == 1) start_verification = 1'b1;
      if (k == 2) start_verification = 1'b0;
      if (k == 6) btn_one = 1'b0;
      @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_drop_done: got %0d pulses expected 1", dones); end
    checks++; if ({ones_count, final_analysis} !== {3'd2, 1'b1}) begin errors++; $display("FAIL busy_drop_result: got ones=%0d final=%b expected 2/1", ones_count, final_analysis); end
    checks++; if ({last_digits, digit_count} !== {4'b0110, 3'd3}) begin errors++; $display("FAIL busy_drop_entry: got %b/%0d expected 0110/3", last_digits, digit_count); end
  endtask

  task automatic test_reset_abort;
    int dones;
    dones = 0;
    @(negedge clk);
    start_verification = 1'b1;
    @(negedge clk);
    start_verification = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({busy, done, window_full, final_analysis} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b expected 0000", {busy, done, window_full, final_analysis}); end
    checks++; if ({last_digits, digit_count, ones_count} !== 10'd0) begin errors++; $display("FAIL abort_values: got %b/%0d/%0d expected 0/0/0", last_digits, digit_count, ones_count); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones); end
    start_verification = 1'b1;
    @(negedge clk);
    start_verification = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL abort_fresh_done: got %0d pulses expected 1", dones); end
    checks++; if ({ones_count, final_analysis} !== {3'd0, 1'b0}) begin errors++; $display("FAIL abort_fresh_result: got ones=%0d final=%b expected 0/0", ones_count, final_analysis); end
  endtask

  task automatic test_back_to_back;
    logic [13:0] busy_m, done_m;
    busy_m = '0; done_m = '0;
    press(1'b1);
    @(negedge clk);
    start_verification = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      busy_m[k] = busy;
      done_m[k] = done;
      if (k == 6) start_verification = 1'b0;
      @(negedge clk);
    end
    checks++; if (busy_m !== 14'h03CF) begin errors++; $display("FAIL b2b_busy: got %b expected 00001111001111", busy_m); end
    checks++; if (done_m !== 14'h0820) begin errors++; $display("FAIL b2b_done: got %b expected 00100000100000", done_m); end
    checks++; if ({ones_count, final_analysis} !== {3'd1, 1'b0}) begin errors++; $display("FAIL b2b_result: got ones=%0d final=%b expected 1/0", ones_count, final_analysis); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_entry();
    test_analysis();
    test_low();
    test_drop();
    test_busy_drop();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
